hub75_scan_driver: RTL and testbench
====================================

Name: hub75_scan_driver

Overview:
- Self-contained HUB75 LED-matrix panel driver for a 64x64, 1/32-scan panel.
- Generates a fixed test pattern internally, shifts it into the panel one row pair at a time, latches it, drives the row address (A..E), and enables the LEDs for a fixed on-time.
- Sits directly behind the PLL: clocked by the PLL output and held in reset until the PLL reports lock.
- Asserts done once per completed frame.

Parameters:
- COLS, 64: columns shifted per row pair; must be at least 8.
- ROW_PAIRS, 32: row pairs per frame; at most 32, since the address is 5 bits.
- DISPLAY_CYCLES, 64: clk_in cycles OE_N is held low per row pair; must be at least 1.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- locked  input  1  asynchronous active-low reset (PLL lock): 0 = reset, 1 = run.
- R1_data, G1_data, B1_data  output  1 each  upper-half pixel colour bits.
- R2_data, G2_data, B2_data  output  1 each  lower-half pixel colour bits.
- A, B, C, D, E  output  1 each  row-pair address, A = LSB, E = MSB.
- clk_out  output  1  panel shift clock; the panel samples data on its rising edge.
- LAT  output  1  latch strobe, active-high.
- OE_N  output  1  LED output enable, active-low.
- done  output  1  one-cycle end-of-frame pulse.

Behaviour:
- Registers: all outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (locked=0):
  - Immediately and asynchronously: all data outputs 0, A..E 0, clk_out 0, LAT 0, OE_N 1 (panel blanked), done 0.
  - Internal state returns to SHIFT, column 0, row 0, phase LOW.
  - Mid-operation reset behaves identically; there is no partial-frame resume.
- Edge numbering: edge 1 is the first rising clk_in edge after locked rises.
- States: SHIFT -> LATCH -> DISPLAY -> SHIFT (next row).
- SHIFT, per column c = 0..COLS-1, over two edges:
  - Phase LOW: drive pixel(r,c) on the data outputs, clk_out=0.
  - Phase HIGH: clk_out=1, data held.
  - Duration 2*COLS edges. OE_N=1, LAT=0 throughout.
- LATCH, 1 edge:
  - clk_out=0, LAT=1, OE_N=1, data outputs 0.
  - A..E <= r, updated on this edge so the address settles while the panel is blanked.
- DISPLAY, DISPLAY_CYCLES edges: OE_N=0, LAT=0, clk_out=0, data 0, address held.
- Row period is 2*COLS+1+DISPLAY_CYCLES edges (193 with defaults).
- After the last DISPLAY edge: OE_N returns to 1 on the next edge, which is also the column-0 LOW-phase edge of row r+1.
- Row wrap: after row ROW_PAIRS-1, r wraps to 0.
- done: 1 for exactly the single cycle at the column-0 LOW-phase edge of row 0 following row ROW_PAIRS-1's DISPLAY; 0 otherwise.
  - Default frame period is 32*193 = 6176 cycles.
  - done never asserts before the first full frame.
- Test pattern, for row pair r and column c (bit indices on the binary value):
  - R1=c[0], G1=c[1], B1=c[2].
  - R2=r[0], G2=r[1], B2=r[2].
- Counter widths: column counter clog2(COLS) bits, row counter 5 bits, display counter clog2(DISPLAY_CYCLES+1) bits. All wrap or clear exactly at their terminal counts with no overflow.
- Invariants:
  - LAT and OE_N=0 are never asserted in the same cycle.
  - clk_out is never 1 outside SHIFT.

Test Plan:
- Reset: hold locked=0 and toggle clk_in -> OE_N=1, LAT=0, clk_out=0, A..E=0, all data 0, done=0. Then drop locked asynchronously mid-DISPLAY -> OE_N goes to 1 without waiting for a clock edge.
- First row shift: release locked -> edges 1..128 give 64 clk_out rising pulses (on even edges). Sampled R1,G1,B1 at each clk_out rise equals column bits 0..2, i.e. the pattern 0,1,..,7 repeating. R2,G2,B2 = 000. OE_N=1 throughout.
- Latch and address: edge 129 -> LAT=1, {E,D,C,B,A}=0, OE_N=1. Edges 130..193 -> OE_N=0, LAT=0 (64 cycles). Edge 194 -> OE_N=1, shifting of row 1 begins, and the lower-half data reads R2=1, G2=0, B2=0.
- Row sequencing: over 5 rows (about 1000 cycles, at a 10 ns clock) -> address goes 0,1,2,3,4 at each LATCH. The LAT pulse period is 193 cycles.
- Frame done: run 2 frames -> done pulses once at cycle 6177 and again at cycle 12353, 1 cycle wide. The address wraps from 31 to 0 at the next LATCH.
- Parameter check: COLS=8, DISPLAY_CYCLES=1, ROW_PAIRS=4 -> row period 18 cycles, 8 clk_out pulses per row, done pulse every 72 cycles.

Source files
------------

// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver for a 1/32-scan panel: shifts a generated test pattern
// one row pair at a time, latches it, sets the row address, then lights the LEDs.
module hub75_scan_driver #(
    parameter int COLS           = 64,
    parameter int ROW_PAIRS      = 32,
    parameter int DISPLAY_CYCLES = 64
) (
    input  logic clk_in,
    input  logic locked,
    output logic R1_data,
    output logic G1_data,
    output logic B1_data,
    output logic R2_data,
    output logic G2_data,
    output logic B2_data,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic clk_out,
    output logic LAT,
    output logic OE_N,
    output logic done
);

    localparam int COL_W  = $clog2(COLS);
    localparam int DISP_W = $clog2(DISPLAY_CYCLES + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
    localparam logic [4:0]        ROW_LAST  = 5'(ROW_PAIRS - 1);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISPLAY_CYCLES - 1);
    localparam logic [DISP_W-1:0] DISP_ONE  = DISP_W'(1);

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_DISPLAY = 2'd2
    } state_t;

    // Internal state describes what the outputs must show after the next edge.
    state_t              state, state_nx;
    logic [COL_W-1:0]    col, col_nx;
    logic                phase, phase_nx;
    logic [4:0]          row, row_nx;
    logic [DISP_W-1:0]   disp_cnt, disp_nx;
    logic                wrap, wrap_nx;

    logic [2:0] upper_nx;
    logic [2:0] lower_nx;
    logic [4:0] addr_nx;
    logic       clk_out_nx;
    logic       lat_nx;
    logic       oe_n_nx;
    logic       done_nx;

    always_ff @(posedge clk_in or negedge locked) begin
        if (!locked) begin
            state    <= ST_SHIFT;
            col      <= '0;
            phase    <= 1'b0;
            row      <= '0;
            disp_cnt <= '0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            phase    <= phase_nx;
            row      <= row_nx;
            disp_cnt <= disp_nx;
            wrap     <= wrap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col;
        phase_nx = phase;
        row_nx   = row;
        disp_nx  = disp_cnt;
        wrap_nx  = wrap;
        case (state)
            ST_SHIFT: begin
                if (!phase) begin
                    phase_nx = 1'b1;
                    if (col == '0) begin
                        wrap_nx = 1'b0;
                    end
                end else begin
                    phase_nx = 1'b0;
                    if (col == COL_LAST) begin
                        col_nx   = '0;
                        state_nx = ST_LATCH;
                    end else begin
                        col_nx = col + COL_ONE;
                    end
                end
            end
            ST_LATCH: begin
                disp_nx  = '0;
                state_nx = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (disp_cnt == DISP_LAST) begin
                    disp_nx  = '0;
                    state_nx = ST_SHIFT;
                    // The frame-done pulse is emitted on the next column-0 edge.
                    if (row == ROW_LAST) begin
                        row_nx  = '0;
                        wrap_nx = 1'b1;
                    end else begin
                        row_nx = row + 5'd1;
                    end
                end else begin
                    disp_nx = disp_cnt + DISP_ONE;
                end
            end
            default: begin
                state_nx = ST_SHIFT;
                col_nx   = '0;
                phase_nx = 1'b0;
                row_nx   = '0;
                disp_nx  = '0;
                wrap_nx  = 1'b0;
            end
        endcase
    end

    always_comb begin
        upper_nx   = 3'b000;
        lower_nx   = 3'b000;
        addr_nx    = {E, D, C, B, A};
        clk_out_nx = 1'b0;
        lat_nx     = 1'b0;
        oe_n_nx    = 1'b1;
        done_nx    = 1'b0;
        case (state)
            ST_SHIFT: begin
                upper_nx   = {col[0], col[1], col[2]};
                lower_nx   = {row[0], row[1], row[2]};
                clk_out_nx = phase;
                done_nx    = !phase && (col == '0) && wrap;
            end
            ST_LATCH: begin
                lat_nx  = 1'b1;
                addr_nx = row;
            end
            ST_DISPLAY: begin
                oe_n_nx = 1'b0;
            end
            default: begin
                oe_n_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge locked) begin
        if (!locked) begin
            {R1_data, G1_data, B1_data} <= 3'b000;
            {R2_data, G2_data, B2_data} <= 3'b000;
            {E, D, C, B, A}             <= 5'd0;
            clk_out                     <= 1'b0;
            LAT                         <= 1'b0;
            OE_N                        <= 1'b1;
            done                        <= 1'b0;
        end else begin
            {R1_data, G1_data, B1_data} <= upper_nx;
            {R2_data, G2_data, B2_data} <= lower_nx;
            {E, D, C, B, A}             <= addr_nx;
            clk_out                     <= clk_out_nx;
            LAT                         <= lat_nx;
            OE_N                        <= oe_n_nx;
            done                        <= done_nx;
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: a default 64x32 instance and a small 8-column instance
// are compared edge by edge against an edge-number-based model of the scan timing.
module tb_hub75_scan_driver;

    logic clk_in = 1'b0;
    logic locked = 1'b0;

    always #5 clk_in = ~clk_in;

    // Output vectors: {R1,G1,B1,R2,G2,B2,E,D,C,B,A,clk_out,LAT,OE_N,done}
    logic r1, g1, b1, r2, g2, b2, a, b, c, d, e, ck, lat, oen, dn;
    logic r1_s, g1_s, b1_s, r2_s, g2_s, b2_s, a_s, b_s, c_s, d_s, e_s, ck_s, lat_s, oen_s, dn_s;
    logic [14:0] obs, obs_s;

    assign obs   = {r1, g1, b1, r2, g2, b2, e, d, c, b, a, ck, lat, oen, dn};
    assign obs_s = {r1_s, g1_s, b1_s, r2_s, g2_s, b2_s, e_s, d_s, c_s, b_s, a_s, ck_s, lat_s, oen_s, dn_s};

    hub75_scan_driver dut (
        .clk_in(clk_in), .locked(locked),
        .R1_data(r1), .G1_data(g1), .B1_data(b1),
        .R2_data(r2), .G2_data(g2), .B2_data(b2),
        .A(a), .B(b), .C(c), .D(d), .E(e),
        .clk_out(ck), .LAT(lat), .OE_N(oen), .done(dn)
    );

    hub75_scan_driver #(.COLS(8), .ROW_PAIRS(4), .DISPLAY_CYCLES(1)) dut_s (
        .clk_in(clk_in), .locked(locked),
        .R1_data(r1_s), .G1_data(g1_s), .B1_data(b1_s),
        .R2_data(r2_s), .G2_data(g2_s), .B2_data(b2_s),
        .A(a_s), .B(b_s), .C(c_s), .D(d_s), .E(e_s),
        .clk_out(ck_s), .LAT(lat_s), .OE_N(oen_s), .done(dn_s)
    );

    localparam logic [14:0] RESET_VEC = 15'h0002;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [14:0] exp_q[$];
    logic [14:0] exp_s_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge=%0d got=%h want=%h", tag, n, got, want);
        end
    endtask

    // Expected outputs after edge number en (1-based) for a given geometry.
    function automatic logic [14:0] model(input int en, input int cols, input int rps, input int dcy);
        int per, k, frow, r, col;
        logic [2:0] up, lo;
        logic [4:0] addr;
        logic eck, elat, eoen, edn;
        per  = 2 * cols + 1 + dcy;
        k    = (en - 1) % per;
        frow = (en - 1) / per;
        r    = frow % rps;
        col  = k / 2;
        up   = 3'b000;
        lo   = 3'b000;
        eck  = 1'b0;
        elat = 1'b0;
        eoen = 1'b1;
        addr = 5'(r);
        if (k < 2 * cols) begin
            up   = {col[0], col[1], col[2]};
            lo   = {r[0], r[1], r[2]};
            eck  = (k % 2) == 1;
            addr = (frow == 0) ? 5'd0 : 5'((r + rps - 1) % rps);
        end else if (k == 2 * cols) begin
            elat = 1'b1;
        end else begin
            eoen = 1'b0;
        end
        edn = (k == 0) && (r == 0) && (frow > 0);
        return {up, lo, addr, eck, elat, eoen, edn};
    endfunction

    task automatic step_and_check(input string tag);
        @(posedge clk_in);
        n++;
        exp_q.push_back(model(n, 64, 32, 64));
        exp_s_q.push_back(model(n, 8, 4, 1));
        @(negedge clk_in);
        check({tag, "_main"}, {17'd0, obs}, {17'd0, exp_q.pop_front()});
        check({tag, "_small"}, {17'd0, obs_s}, {17'd0, exp_s_q.pop_front()});
    endtask

    int ck_rises_row0;
    int ck_rises_row0_s;
    int done_edges[$];
    int done_edges_s;
    int last_lat;

    initial begin
        ck_rises_row0   = 0;
        ck_rises_row0_s = 0;
        done_edges_s    = 0;
        last_lat        = 0;

        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_main", {17'd0, obs}, {17'd0, RESET_VEC});
        check("reset_small", {17'd0, obs_s}, {17'd0, RESET_VEC});
        locked = 1'b1;

        // Two full default frames, then into row 0's display window.
        while (!(n > 12353 && ((n - 1) % 193) == 150)) begin
            step_and_check("scan");
            if (n <= 128 && ck) ck_rises_row0++;
            if (n <= 16 && ck_s) ck_rises_row0_s++;
            if (dn) done_edges.push_back(n);
            if (dn_s) done_edges_s++;
            if (lat) begin
                if (last_lat != 0) check("lat_period", n - last_lat, 193);
                last_lat = n;
            end
        end

        check("ck_rises_row0", ck_rises_row0, 64);
        check("ck_rises_row0_small", ck_rises_row0_s, 8);
        check("done_count", done_edges.size(), 2);
        if (done_edges.size() == 2) begin
            check("done_edge_1", done_edges[0], 6177);
            check("done_edge_2", done_edges[1], 12353);
        end
        check("done_count_small", done_edges_s, (n - 1) / 72);
        check("oe_before_async_reset", {31'd0, oen}, 32'd0);

        // Asynchronous reset in the middle of a low clock phase.
        #2;
        locked = 1'b0;
        #1;
        check("async_reset_main", {17'd0, obs}, {17'd0, RESET_VEC});
        check("async_reset_small", {17'd0, obs_s}, {17'd0, RESET_VEC});
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("held_reset_main", {17'd0, obs}, {17'd0, RESET_VEC});

        // Restart must begin a fresh frame from row 0, column 0.
        locked = 1'b1;
        n = 0;
        repeat (400) step_and_check("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
